// File: rtl/polyphase_fir_x_param_if.sv
// polyphase_fir_x_param_if: input and output pixel streams of the X decimating filter.
interface polyphase_fir_x_param_if #(parameter int DATA_W = 8);
   logic              in_valid, in_ready, in_eol, out_valid, out_ready;
   logic [DATA_W-1:0] in_pix, out_pix;
   modport master (output in_valid, in_pix, in_eol, out_ready, input in_ready, out_valid, out_pix);
   modport slave (input in_valid, in_pix, in_eol, out_ready, output in_ready, out_valid, out_pix);
endinterface

// File: rtl/polyphase_fir_x_param.sv
// polyphase_fir_x_param: horizontal polyphase decimator with shift-add taps, rounding, clamping,
// end-of-line replication and a three-stage (phase capture, tap sums, output) stall-aware pipeline.
module polyphase_fir_x_param #(
   parameter int DATA_W = 8,
   parameter int MAX_PHASES = 8,
   parameter int TERMS = 3,
   parameter int SHIFT_W = 2,
   parameter int NORM_W = 4,
   localparam int CNT_W = $clog2(MAX_PHASES + 1),
   localparam int TERM_W = SHIFT_W + 3,
   localparam int COEF_W = MAX_PHASES * TERMS * TERM_W,
   localparam int AW = DATA_W + 2**SHIFT_W + $clog2(MAX_PHASES * TERMS) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic [CNT_W-1:0]    factor,
   input  logic [COEF_W-1:0]   coef,
   input  logic [NORM_W-1:0]   norm,
   polyphase_fir_x_param_if.slave s,
   output logic                cfg_err
);
   localparam logic [CNT_W-1:0] MAXF = CNT_W'(MAX_PHASES);

   logic [CNT_W-1:0]     cnt, f_cur, f_lat, f_eff, g_f;
   logic [DATA_W-1:0]    ph [MAX_PHASES];
   logic [COEF_W-1:0]    coef_g;
   logic [NORM_W-1:0]    norm_g, b_norm;
   logic                 gv, b_valid, fac_ok, acc_in, done, b_load, c_load;
   logic signed [AW-1:0] tap_c [MAX_PHASES];
   logic signed [AW-1:0] s_b [MAX_PHASES];
   logic signed [AW-1:0] acc, rnd;
   logic [DATA_W-1:0]    pix_c;

   function automatic logic signed [AW-1:0] term_val(input logic [DATA_W-1:0] px, input logic [TERM_W-1:0] fld);
      logic [AW-1:0] mag;
      mag = fld[TERM_W-3] ? AW'(px) << fld[SHIFT_W-1:0] : AW'(px >> fld[SHIFT_W-1:0]);
      return $signed(fld[TERM_W-1] ? (fld[TERM_W-2] ? -mag : mag) : '0);
   endfunction

   // A group's factor is only known once its first pixel is taken, so cnt==0 uses the live input.
   assign fac_ok = factor != '0 && factor <= MAXF;
   assign f_lat = fac_ok ? factor : MAXF;
   assign f_eff = cnt == '0 ? f_lat : f_cur;
   assign acc_in = s.in_valid && s.in_ready;
   assign done = s.in_eol || cnt == f_eff - CNT_W'(1);
   assign c_load = b_valid && (!s.out_valid || s.out_ready);
   assign b_load = gv && (!b_valid || c_load);
   assign s.in_ready = !(gv && b_valid && !c_load);

   always_comb
      for (int p = 0; p < MAX_PHASES; p++) begin
         tap_c[p] = '0;
         if (p < int'(g_f))
            for (int t = 0; t < TERMS; t++)
               tap_c[p] = tap_c[p] + term_val(ph[p], coef_g[(p*TERMS+t)*TERM_W +: TERM_W]);
      end

   always_comb begin
      acc = '0;
      for (int p = 0; p < MAX_PHASES; p++)
         acc = acc + s_b[p];
      rnd = b_norm == '0 ? acc : $signed(acc + (AW'(1) << (b_norm - NORM_W'(1)))) >>> b_norm;
      pix_c = rnd[AW-1] ? '0 : (|rnd[AW-2:DATA_W]) ? '1 : rnd[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         cfg_err <= 1'b0;
      else if (!clr && acc_in && cnt == '0 && !fac_ok)
         cfg_err <= 1'b1;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0; f_cur <= MAXF; g_f <= MAXF; gv <= 1'b0; b_valid <= 1'b0;
         s.out_valid <= 1'b0; s.out_pix <= '0; coef_g <= '0; norm_g <= '0; b_norm <= '0;
         ph <= '{default: '0}; s_b <= '{default: '0};
      end else if (clr) begin
         cnt <= '0; f_cur <= MAXF; g_f <= MAXF; gv <= 1'b0; b_valid <= 1'b0;
         s.out_valid <= 1'b0; s.out_pix <= '0; coef_g <= '0; norm_g <= '0; b_norm <= '0;
         ph <= '{default: '0}; s_b <= '{default: '0};
      end else begin
         if (acc_in) begin
            // End of line replicates the last pixel into every remaining phase.
            for (int p = 0; p < MAX_PHASES; p++)
               if (CNT_W'(p) == cnt || (s.in_eol && CNT_W'(p) > cnt))
                  ph[p] <= s.in_pix;
            if (cnt == '0)
               f_cur <= f_lat;
            cnt <= done ? '0 : cnt + CNT_W'(1);
            if (done) begin
               g_f <= f_eff;
               coef_g <= coef;
               norm_g <= norm;
            end
         end
         gv <= (acc_in && done) || (gv && !b_load);
         if (b_load) begin
            s_b <= tap_c;
            b_norm <= norm_g;
         end
         b_valid <= b_load || (b_valid && !c_load);
         if (c_load)
            s.out_pix <= pix_c;
         s.out_valid <= c_load || (s.out_valid && !s.out_ready);
      end
endmodule

// File: doc/polyphase_fir_x_param.md
# polyphase_fir_x_param

Parametrised horizontal polyphase decimating FIR for the downscaler X path. It collects `factor` consecutive pixels of a scan line into phase registers and weights each phase with a signed shift-add coefficient. The weighted sum is rounded, normalised and clamped to pixel range, and one output pixel is emitted per group over a valid/ready handshake with backpressure. It supersedes the fixed 8-bit / 7-phase / unsigned X filter, and adds signed taps, rounding, saturation, edge replication at end-of-line, and stall handling.

## Interface
Parameters:
- `DATA_W`, 8: pixel width (unsigned).
- `MAX_PHASES`, 8: maximum decimation factor and number of taps.
- `TERMS`, 3: shift terms per tap.
- `SHIFT_W`, 2: shift-amount width. Max shift is 2^SHIFT_W-1.
- `NORM_W`, 4: width of the normalise shift.

Ports:
- `clk` in 1: clock. All state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clr` in 1: synchronous soft clear. Behaves like reset, except `cfg_err` is kept.
- `factor` in clog2(MAX_PHASES+1): decimation factor. Legal range 1..MAX_PHASES.
- `coef` in MAX_PHASES*TERMS*(SHIFT_W+3): per-term fields {en, neg, left, amt[SHIFT_W-1:0]}. Tap p, term t sits at index p*TERMS+t, LSB first.
- `norm` in NORM_W: right-shift applied to the accumulated sum.
- `in_valid` in 1, `in_ready` out 1, `in_pix` in DATA_W, `in_eol` in 1: input pixel stream. `in_eol` marks the last pixel of the line.
- `out_valid` out 1, `out_ready` in 1, `out_pix` out DATA_W: output pixel stream.
- `cfg_err` out 1: sticky flag, set by an illegal `factor`.

## Operation
- **Acceptance and phase capture.** A pixel is accepted on a posedge with `in_valid && in_ready`. It is written to phase register `ph[cnt]`, then `cnt` increments.
- **Factor latching.** `factor` is latched into `F` when `cnt==0` and a pixel is accepted. A value of 0 or greater than MAX_PHASES latches MAX_PHASES and sets `cfg_err`.
- **Group completion.** A group completes when the accepted pixel has `cnt==F-1` or `in_eol=1`. On completion:
  - `cnt` returns to 0 and the group flag `gv` sets.
  - **End-of-line padding:** if `in_eol` arrives at `cnt=k<F-1`, the same pixel is also written to `ph[k+1..F-1]`.
- **Coefficient and norm sampling.** `coef` and `norm` are sampled on the acceptance edge of the completing pixel and held with the group.
- **Stage B: tap sums.** Registered signed tap sum per phase p<F: S_p = Σ_t term(p,t). Phases p≥F contribute 0.
  - Disabled term (`en=0`): 0.
  - Enabled term: `ph[p]<<amt` if `left`, otherwise `ph[p]>>amt` (logical, truncating). The result is negated if `neg`.
- **Stage C: output.**
  - ACC = Σ S_p, signed, width DATA_W + 2^SHIFT_W + clog2(MAX_PHASES*TERMS) + 1. No overflow is possible.
  - R = ACC if `norm==0`, otherwise (ACC + 2^(norm-1)) >>> norm (round half up, arithmetic shift).
  - `out_pix` = clamp(R, 0, 2^DATA_W-1).
- **Stall rules.**
  - Each stage advances when the next stage is empty or is advancing.
  - `out_pix`/`out_valid` hold while `out_valid && !out_ready`.
  - `in_ready=0` exactly when `gv=1` and stage B is full and cannot advance. Otherwise `in_ready=1`.
- **Clear.** `clr` or reset: `cnt=0` and `F=MAX_PHASES`; `gv`, stage-B valid, `out_valid` and `ph[]` are cleared to 0; the in-flight group is dropped.

## Timing
- **Reset values:** `in_ready=1`, `out_valid=0`, `out_pix=0`, `cfg_err=0`.
- **Latency.** Completing pixel accepted at edge T → stage B loaded at T+1 → `out_valid=1` after edge T+2, with no stall. Sustained throughput is one input pixel per clock.
- **Simultaneous events.**
  - A new pixel accepted on the same edge that stage B loads the previous group: stage B uses the old `ph[]` values and the new pixel writes `ph[0]`.
  - `clr` together with an input or output handshake: `clr` wins and nothing is transferred.
- **Reset mid-group** discards partial phases. There is no output for that group.
- `factor` changes in mid-group are ignored until the next group start.
- **`F=1`:** every pixel completes a group, giving a 1:1 filter.

## Test plan
- **Box filter.** `F=4`; every tap has one term {en=1, neg=0, left=1, amt=0}; `norm=2`. Input 10,20,30,40 → `out_pix=25`, `out_valid` 2 cycles after the 4th accept. Input 1,2,2,2 → 2 (rounding: (7+2)>>2).
- **Signed taps and saturation.** `F=2`; tap0 = +4 (left, amt 2); tap1 = −1 (neg). Input 0,255 with `norm=0` → 0 (clamp low). Input 255,0 → 255 (1020 clamped high).
- **End-of-line padding.** `F=4`, box taps, `norm=2`. Input 8,16 with `in_eol` on 16 → phases 8,16,16,16 → 14. The next line restarts at `cnt=0`.
- **Backpressure.** `F=2`, pixels streamed back to back, `out_ready=0` for 6 cycles. `in_ready` falls once B and C are full; all outputs appear in order with no loss or duplication after `out_ready=1`.
- **Illegal factor.** `factor=0` at group start → `F=8`, `cfg_err=1`, and the first output appears after 8 pixels. `clr` keeps `cfg_err`; `rst_n` clears it.
- **Mid-group reset.** `rst_n` low after 2 of 4 pixels → no output; the next 4 pixels produce exactly one correct output.
